// File: rtl/varredura_display_bcd_pkg.sv
// -----------------------------------------------------------------------------
// pkg_display
// Shared definitions for the 4-digit multiplexed 7-segment driver:
//   - active-low segment patterns {g,f,e,d,c,b,a}
//   - 2-bit digit index encoding (bit0 of the anodes = units ... bit3 = sign)
//   - glyph-select enum used between the top and the decoder
// -----------------------------------------------------------------------------
package pkg_display;

    localparam logic [6:0] SEG_BRANCO = 7'h7F;
    localparam logic [6:0] SEG_MENOS  = 7'h3F;
    localparam logic [6:0] SEG_E      = 7'h06;
    localparam logic [6:0] SEG_R      = 7'h2F;
    localparam logic [6:0] SEG_O      = 7'h23;

    typedef enum logic [1:0] {
        IDX_UNIDADES = 2'd0,
        IDX_DEZENAS  = 2'd1,
        IDX_CENTENAS = 2'd2,
        IDX_SINAL    = 2'd3
    } indice_t;

    typedef enum logic [2:0] {
        DIGITO,
        BRANCO,
        MENOS,
        LETRA_E,
        LETRA_R,
        LETRA_O
    } glifo_t;

    // Decimal digit pattern; a non-BCD value falls back to '-'.
    function automatic logic [6:0] seg_digito(input logic [3:0] valor);
        logic [6:0] seg;
        case (valor)
            4'd0:    seg = 7'h40;
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h10;
            default: seg = SEG_MENOS;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/varredura_display_bcd_decodificador.sv
// -----------------------------------------------------------------------------
// decodificador_7seg
// Combinational glyph decoder.
//   i_glifo      glyph to draw (digit, blank, minus, or a letter of "Erro")
//   i_valor      BCD value, only used when i_glifo = DIGITO
//   o_segmentos  active-low pattern {g,f,e,d,c,b,a}
// -----------------------------------------------------------------------------
module decodificador_7seg
    import pkg_display::*;
(
    input  glifo_t       i_glifo,
    input  logic [3:0]   i_valor,
    output logic [6:0]   o_segmentos
);

    always_comb begin
        o_segmentos = SEG_BRANCO;
        case (i_glifo)
            DIGITO:  o_segmentos = seg_digito(i_valor);
            MENOS:   o_segmentos = SEG_MENOS;
            LETRA_E: o_segmentos = SEG_E;
            LETRA_R: o_segmentos = SEG_R;
            LETRA_O: o_segmentos = SEG_O;
            default: o_segmentos = SEG_BRANCO;
        endcase
    end

endmodule

// File: rtl/varredura_display_bcd.sv
// -----------------------------------------------------------------------------
// varredura_display_bcd
// Time-multiplexed driver for a 4-digit common-anode 7-segment display.
// Captures BCD hundreds/tens/units plus sign and error flags on i_carregar and
// scans them out with leading-zero blanking, a minus sign and an "Erro" text.
//   i_clock      system clock (rising edge)
//   i_reset      synchronous active-high reset
//   i_carregar   load strobe for all data inputs
//   i_centenas / i_dezenas / i_unidades   BCD digits
//   i_negativo   result is negative
//   i_erro       overflow / invalid operation, overrides the digits
//   o_segmentos  active-low {g,f,e,d,c,b,a}
//   o_anodos     active-low digit enables, bit0 = units ... bit3 = sign
//   o_quadro     one-cycle pulse at each frame wrap
// Every output is registered from (index, slot counter, shadows).
// -----------------------------------------------------------------------------
module varredura_display_bcd
    import pkg_display::*;
#(
    parameter int DIV_REFRESH = 50000,
    parameter int TEMPO_MORTO = 500
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_carregar,
    input  logic [3:0]  i_centenas,
    input  logic [3:0]  i_dezenas,
    input  logic [3:0]  i_unidades,
    input  logic        i_negativo,
    input  logic        i_erro,
    output logic [6:0]  o_segmentos,
    output logic [3:0]  o_anodos,
    output logic        o_quadro
);

    localparam int             CW       = $clog2(DIV_REFRESH);
    localparam logic [CW-1:0]  CONT_MAX = CW'(DIV_REFRESH - 1);

    logic [CW-1:0] r_cont;
    indice_t       r_indice;
    logic          r_fim_quadro;
    logic [3:0]    r_centenas;
    logic [3:0]    r_dezenas;
    logic [3:0]    r_unidades;
    logic          r_negativo;
    logic          r_erro;

    logic          w_fim_slot;
    logic          w_branco;
    glifo_t        w_glifo;
    logic [3:0]    w_valor;
    logic [6:0]    w_seg;

    assign w_fim_slot = (r_cont == CONT_MAX);
    assign w_branco   = (32'(r_cont) < TEMPO_MORTO);

    // Slot counter, digit index and frame-wrap marker
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_cont       <= '0;
            r_indice     <= IDX_UNIDADES;
            r_fim_quadro <= 1'b0;
        end else begin
            // Marks that the state about to be entered is the first slot of a
            // new frame; it reaches the pin together with that slot's first output.
            r_fim_quadro <= w_fim_slot && (r_indice == IDX_SINAL);
            if (w_fim_slot) begin
                r_cont   <= '0;
                r_indice <= indice_t'(r_indice + 2'd1);
            end else begin
                r_cont <= r_cont + 1'b1;
            end
        end
    end

    // Shadow registers
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_centenas <= '0;
            r_dezenas  <= '0;
            r_unidades <= '0;
            r_negativo <= 1'b0;
            r_erro     <= 1'b0;
        end else if (i_carregar) begin
            r_centenas <= i_centenas;
            r_dezenas  <= i_dezenas;
            r_unidades <= i_unidades;
            r_negativo <= i_negativo;
            r_erro     <= i_erro;
        end
    end

    // Glyph selection for the digit currently being scanned
    always_comb begin
        w_glifo = BRANCO;
        w_valor = 4'd0;
        if (r_erro) begin
            case (r_indice)
                IDX_SINAL:    w_glifo = LETRA_E;
                IDX_CENTENAS: w_glifo = LETRA_R;
                IDX_DEZENAS:  w_glifo = LETRA_R;
                default:      w_glifo = LETRA_O;
            endcase
        end else begin
            case (r_indice)
                IDX_SINAL: w_glifo = r_negativo ? MENOS : BRANCO;
                IDX_CENTENAS: begin
                    w_valor = r_centenas;
                    w_glifo = (r_centenas == 4'd0) ? BRANCO : DIGITO;
                end
                IDX_DEZENAS: begin
                    // An invalid (>9) hundreds nibble is nonzero, so tens stay lit.
                    w_valor = r_dezenas;
                    w_glifo = (r_centenas == 4'd0 && r_dezenas == 4'd0) ? BRANCO : DIGITO;
                end
                default: begin
                    w_valor = r_unidades;
                    w_glifo = DIGITO;
                end
            endcase
            // Non-BCD nibble: '-' in its own position
            if (w_glifo == DIGITO && w_valor > 4'd9) begin
                w_glifo = MENOS;
            end
        end
    end

    decodificador_7seg u_decodificador (
        .i_glifo     (w_glifo),
        .i_valor     (w_valor),
        .o_segmentos (w_seg)
    );

    // Output registers
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            o_anodos    <= 4'b1111;
            o_segmentos <= SEG_BRANCO;
            o_quadro    <= 1'b0;
        end else begin
            o_anodos    <= w_branco ? 4'b1111 : ~(4'b0001 << r_indice);
            o_segmentos <= w_branco ? SEG_BRANCO : w_seg;
            o_quadro    <= r_fim_quadro;
        end
    end

endmodule

// File: doc/varredura_display_bcd.md
# varredura_display_bcd

Time-multiplexed driver for a 4-digit common-anode 7-segment display. It sits directly downstream of the binary→BCD converter: it captures the three BCD digits (Centenas/Dezenas/Unidades) plus sign and error flags from the ALU result path. It then scans them onto the board display with leading-zero blanking, a minus sign, and an "Erro" message. All outputs are registered, and the block runs continuously from a single clock.

## Interface
- DIV_REFRESH, 50000: clock cycles per digit slot (1 ms at 50 MHz); must be ≥ 2.
- TEMPO_MORTO, 500: blank (ghosting guard) cycles at the start of each slot; 0 ≤ TEMPO_MORTO < DIV_REFRESH.

- Clock  in  1  system clock; all logic on the rising edge.
- Reset  in  1  synchronous, active-high.
- Carregar  in  1  load strobe; captures all data inputs on the same edge.
- Centenas  in  4  BCD hundreds.
- Dezenas  in  4  BCD tens.
- Unidades  in  4  BCD units.
- Negativo  in  1  result is negative.
- Erro  in  1  overflow/invalid operation; overrides the digits.
- Segmentos  out  7  {g,f,e,d,c,b,a}, active-low.
- Anodos  out  4  digit enables, active-low; bit0 = units … bit3 = sign digit.
- Quadro  out  1  one-cycle pulse at each frame wrap.

## Operation
- Shadow registers hold C/D/U/Negativo/Erro.
  - Loaded on any edge with Carregar=1; hold otherwise.
  - Carregar held high loads every cycle.
  - Reset clears the shadows to 0.
- Slot counter Cont runs 0..DIV_REFRESH-1, with width $clog2(DIV_REFRESH).
  - Digit index Indice advances 0→1→2→3→0 when Cont = DIV_REFRESH-1.
  - Cont returns to 0 at the same edge.
- Phase within a slot:
  - BLANK while Cont < TEMPO_MORTO: Anodos=1111, Segmentos=7F.
  - ON otherwise: Anodos = ~(1<<Indice), and Segmentos = the pattern for that digit.
- Digit content when Erro=0:
  - Index 3: '-' if Negativo, else blank.
  - Index 2: Centenas; blank if Centenas=0.
  - Index 1: Dezenas; blank if Centenas=0 and Dezenas=0.
  - Index 0: Unidades, always shown (0 shows '0').
- Digit content when Erro=1: indices 3..0 show 'E','r','r','o' regardless of the other fields.
- Any BCD nibble > 9 (Erro=0) shows '-' in its own position. It counts as nonzero for the blanking rule.
- Patterns, active-low:
  - Digits 0..9: 40,79,24,30,19,12,02,78,00,10.
  - Blank 7F, '-' 3F, 'E' 06, 'r' 2F, 'o' 23.

## Timing
- Reset values:
  - Cont=0, Indice=0, shadows=0.
  - Outputs: Anodos=1111, Segmentos=7F, Quadro=0.
- Outputs are registered from (Indice, Cont, shadows), giving exactly 1-cycle latency from internal state to pins.
- The first ON output after Reset release appears after edge TEMPO_MORTO+1.
- Each slot gives TEMPO_MORTO blank cycles, then DIV_REFRESH-TEMPO_MORTO cycles with one anode low. Two anodes are never low simultaneously.
- Quadro goes high for exactly one cycle, coincident with the first output cycle of the index-0 slot after index 3. It is not asserted on the first frame after reset.
- A load becomes visible at the pins on the next ON cycle of the affected digit. The first possible cycle is the second edge after the Carregar edge.
- Reset mid-slot or mid-frame: Reset wins over Carregar on the same edge. The next cycle's outputs are the reset values and scanning restarts from index 0.

## Structure
- Package pkg_display:
  - segment pattern constants (digits, blank, minus, E, r, o);
  - 2-bit digit index encoding;
  - a glyph-select enum (DIGITO, BRANCO, MENOS, LETRA_E, LETRA_R, LETRA_O).
- Sub-module decodificador_7seg: combinational; inputs glyph select + 4-bit value, output active-low 7-bit pattern.
- Top module: counter, index, shadow registers, blanking/glyph selection, output registers.

## Test plan
All scenarios use DIV_REFRESH=8, TEMPO_MORTO=2.
- Reset, then release → Anodos=1111 and Segmentos=7F for 2 cycles. Then Anodos=1110 for 6 cycles, then 1111 ×2, then 1101. Quadro=0 until the first wrap, then a 1-cycle pulse every 32 cycles.
- Load C=2, D=5, U=5, Negativo=1 → per frame, indices 3..0 show 3F, 24, 12, 12.
- Load C=0, D=0, U=0 → indices 3..1 show 7F and index 0 shows 40. Load C=0, D=7, U=0 → index 2 7F, index 1 78, index 0 40.
- Load Erro=1 with C=1, D=2, U=3 → 06, 2F, 2F, 23. A subsequent load with Erro=0 restores the digits.
- Load C=0, D=0xC, U=1 → index 1 shows 3F and index 2 is blank.
- Assert Reset mid-slot of index 2 with Carregar=1 on the same edge → next cycle Anodos=1111. Shadows are zero (index 0 later shows 40), and the scan restarts at index 0.
